sd_bus_seq: RTL and testbench



---
 rtl/sd_pkg.sv | 35 +++
 rtl/sd_clk_div.sv | 41 ++++
 rtl/sd_bus_seq.sv | 195 +++++++++++++++++++
 tb/tb_sd_bus_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// sd_pkg -- shared definitions for the SD bus sequencer.
//
// Holds the Avalon register addresses, the STATUS and CTRL bit positions,
// and the FSM and transfer-mode encodings used by sd_bus_seq.
package sd_pkg;

  // Register map (Avalon word addresses)
  localparam logic [1:0] SD_ADDR_DIV  = 2'd0;
  localparam logic [1:0] SD_ADDR_DATA = 2'd1;
  localparam logic [1:0] SD_ADDR_STAT = 2'd2;
  localparam logic [1:0] SD_ADDR_CTRL = 2'd3;

  // STATUS = {5'b0, ovr, done, busy}
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVR  = 2;

  // CTRL bits
  localparam int CTRL_OE     = 0;
  localparam int CTRL_IRQ_EN = 1;

  // Sequencer states: IDLE parks SD_CLK low, LOW/HIGH are the two SD_CLK halves
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } sd_state_t;

  // What the running transfer does with CMD
  typedef enum logic {
    MODE_BYTE = 1'b0,
    MODE_IDLE = 1'b1
  } sd_mode_t;

endpackage

// File: rtl/sd_clk_div.sv
// sd_clk_div -- half-period counter for the SD clock.
//
// Counts clk cycles while 'run' is high and pulses 'tick' on the last cycle
// of each SD_CLK half-period, i.e. every div+1 cycles.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   run      in   counter enabled (sequencer not idle)
//   restart  in   force the count back to zero (new transfer start)
//   div      in   live divider value, half-period = div+1 cycles
//   tick     out  last cycle of the current half-period
module sd_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // Compare with >= so that lowering DIV below the current count ends the
  // half-period instead of letting the counter run round the full range.
  assign tick = run && (cnt >= div);

  // Count up to the live DIV, then wrap to zero for the next half-period.
  always_ff @(posedge clk) begin
    if (reset || restart || !run) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/sd_bus_seq.sv
// sd_bus_seq -- Avalon-MM slave that drives the SD card CLK and CMD lines.
//
// A write to DATA shifts one byte out on CMD (MSB first) while capturing the
// card's CMD line on each SD_CLK rising edge; a write to STAT produces
// writedata+1 idle clocks with CMD held high.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   address, chipselect,   Avalon-MM slave, readLatency 0
//   write_n, writedata,
//   read_n, readdata
//   sd_clk                 SD clock pin
//   sd_cmd_out, sd_cmd_oe  CMD output value and drive enable
//   sd_cmd_in              CMD pin input, already synchronised
//   irq                    (only with SD_BUS_SEQ_IRQ_EN) done & CTRL.bit1
//
// Build option: define SD_BUS_SEQ_IRQ_EN to add the irq output and make
// CTRL.bit1 a read/write interrupt enable.
module sd_bus_seq
  import sd_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic [7:0] writedata,
  input  logic       read_n,
  output logic [7:0] readdata,
  output logic       sd_clk,
  output logic       sd_cmd_out,
  output logic       sd_cmd_oe,
  input  logic       sd_cmd_in
`ifdef SD_BUS_SEQ_IRQ_EN
  ,
  output logic       irq
`endif
);

  sd_state_t        state, state_next;
  sd_mode_t         mode;
  logic [DIV_W-1:0] div_q;
  logic [7:0]       tx, rx;
  logic [8:0]       clk_left;
  logic             busy, done, ovr;
  logic             ctrl_oe;
  logic             sd_clk_q, cmd_q;
  logic             tick;
  logic             wr, rd, start_req, go_start, last_clk;
`ifdef SD_BUS_SEQ_IRQ_EN
  logic             irq_en;
`endif

  assign wr        = chipselect && !write_n;
  assign rd        = chipselect && !read_n;
  assign start_req = wr && ((address == SD_ADDR_DATA) || (address == SD_ADDR_STAT));
  assign go_start  = start_req && (state == ST_IDLE);
  assign last_clk  = (clk_left == 9'd1);

  sd_clk_div #(.DIV_W(DIV_W)) u_div (
    .clk     (clk),
    .reset   (reset),
    .run     (state != ST_IDLE),
    .restart (go_start),
    .div     (div_q),
    .tick    (tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: each half-period ends on a divider tick; the clock count
  // decides whether a falling edge starts another bit or finishes.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (go_start) state_next = ST_LOW;
      ST_LOW:  if (tick) state_next = ST_HIGH;
      ST_HIGH: if (tick) state_next = last_clk ? ST_IDLE : ST_LOW;
      default: state_next = ST_IDLE;
    endcase
  end

  // Registers, flags and the shift datapath. Flag clears come before the
  // sets so a set in the same cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= DIV_W'(DIV_RESET);
      ctrl_oe  <= 1'b0;
`ifdef SD_BUS_SEQ_IRQ_EN
      irq_en   <= 1'b0;
`endif
      mode     <= MODE_BYTE;
      tx       <= 8'h00;
      rx       <= 8'h00;
      clk_left <= 9'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovr      <= 1'b0;
      sd_clk_q <= 1'b0;
      cmd_q    <= 1'b1;
    end else begin
      if (wr && (address == SD_ADDR_DIV)) div_q <= DIV_W'(writedata);
      if (wr && (address == SD_ADDR_CTRL)) begin
        ctrl_oe <= writedata[CTRL_OE];
`ifdef SD_BUS_SEQ_IRQ_EN
        irq_en  <= writedata[CTRL_IRQ_EN];
`endif
      end

      if (rd && (address == SD_ADDR_DATA)) done <= 1'b0;
      if (rd && (address == SD_ADDR_STAT)) ovr <= 1'b0;
      if (start_req && (state != ST_IDLE)) ovr <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (go_start) begin
            busy     <= 1'b1;
            done     <= 1'b0;
            sd_clk_q <= 1'b0;
            if (address == SD_ADDR_DATA) begin
              mode     <= MODE_BYTE;
              tx       <= writedata;
              clk_left <= 9'd8;
              cmd_q    <= writedata[7];
            end else begin
              mode     <= MODE_IDLE;
              clk_left <= {1'b0, writedata} + 9'd1;
              cmd_q    <= 1'b1;
            end
          end
        end
        ST_LOW: begin
          if (tick) begin
            sd_clk_q <= 1'b1;
            if (mode == MODE_BYTE) rx <= {rx[6:0], sd_cmd_in};
          end
        end
        ST_HIGH: begin
          if (tick) begin
            sd_clk_q <= 1'b0;
            if (last_clk) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              cmd_q <= 1'b1;
            end else begin
              clk_left <= clk_left - 9'd1;
              tx       <= {tx[6:0], 1'b0};
              cmd_q    <= (mode == MODE_BYTE) ? tx[6] : 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Combinational read mux
  always_comb begin
    readdata = 8'h00;
    case (address)
      SD_ADDR_DIV:  readdata = 8'(div_q);
      SD_ADDR_DATA: readdata = rx;
      SD_ADDR_STAT: begin
        readdata[STAT_BUSY] = busy;
        readdata[STAT_DONE] = done;
        readdata[STAT_OVR]  = ovr;
      end
      SD_ADDR_CTRL: begin
        readdata[CTRL_OE] = ctrl_oe;
`ifdef SD_BUS_SEQ_IRQ_EN
        readdata[CTRL_IRQ_EN] = irq_en;
`endif
      end
      default: readdata = 8'h00;
    endcase
  end

  assign sd_clk     = sd_clk_q;
  assign sd_cmd_out = cmd_q;
  assign sd_cmd_oe  = ctrl_oe;
`ifdef SD_BUS_SEQ_IRQ_EN
  assign irq        = done && irq_en;
`endif

endmodule

// File: tb/tb_sd_bus_seq.sv
// tb_sd_bus_seq -- self-checking bench for sd_bus_seq.
//
// Register access is checked from a vector table; byte transfer, idle clocks,
// overrun, reset mid-transfer and (when SD_BUS_SEQ_IRQ_EN is defined) irq are
// checked with hand-written sequences. CMD is looped back to sd_cmd_in.
module tb_sd_bus_seq;
  import sd_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] address;
  logic       chipselect;
  logic       write_n;
  logic [7:0] writedata;
  logic       read_n;
  logic [7:0] readdata;
  logic       sd_clk;
  logic       sd_cmd_out;
  logic       sd_cmd_oe;
  logic       sd_cmd_in;
  logic       loop_en;
`ifdef SD_BUS_SEQ_IRQ_EN
  logic       irq;
  localparam logic [7:0] CTRL_RB = 8'h03;
`else
  localparam logic [7:0] CTRL_RB = 8'h01;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic       is_wr;
    logic [1:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  assign sd_cmd_in = loop_en ? sd_cmd_out : 1'b1;

  always #5 clk = ~clk;

  sd_bus_seq dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .read_n     (read_n),
    .readdata   (readdata),
    .sd_clk     (sd_clk),
    .sd_cmd_out (sd_cmd_out),
    .sd_cmd_oe  (sd_cmd_oe),
    .sd_cmd_in  (sd_cmd_in)
`ifdef SD_BUS_SEQ_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // All bus tasks start and end one time unit after a rising edge.
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    #2 d = readdata;
    @(posedge clk); #1;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_not_busy(input int budget, output logic ok);
    logic [7:0] s;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      bus_read(SD_ADDR_STAT, s);
      if (!s[STAT_BUSY]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    logic [7:0] d;
    if (v.is_wr) begin
      bus_write(v.addr, v.data);
    end else begin
      bus_read(v.addr, d);
      checkOutput($sformatf("vec%0d read addr%0d", idx, v.addr), d, v.exp);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d, tx_byte, captured;
    logic       prev_clk, ok, timed_out;
    int         edges, busy_cycles, clk_errs, cmd_errs, busy_errs;

    vecs[0]  = '{1'b0, SD_ADDR_DIV,  8'h00, 8'h3F};
    vecs[1]  = '{1'b0, SD_ADDR_DATA, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, SD_ADDR_STAT, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, SD_ADDR_CTRL, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, SD_ADDR_DIV,  8'h05, 8'h00};
    vecs[5]  = '{1'b0, SD_ADDR_DIV,  8'h00, 8'h05};
    vecs[6]  = '{1'b1, SD_ADDR_CTRL, 8'hFF, 8'h00};
    vecs[7]  = '{1'b0, SD_ADDR_CTRL, 8'h00, CTRL_RB};
    vecs[8]  = '{1'b1, SD_ADDR_CTRL, 8'h00, 8'h00};
    vecs[9]  = '{1'b0, SD_ADDR_CTRL, 8'h00, 8'h00};
    vecs[10] = '{1'b1, SD_ADDR_DIV,  8'h01, 8'h00};
    vecs[11] = '{1'b0, SD_ADDR_DIV,  8'h00, 8'h01};

    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    read_n = 1'b1; writedata = 8'h00; loop_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("reset sd_clk", sd_clk, 1'b0);
    checkOutput("reset sd_cmd_out", sd_cmd_out, 1'b1);
    checkOutput("reset sd_cmd_oe", sd_cmd_oe, 1'b0);

    for (int i = 0; i < 12; i++) applyStimulus(i, vecs[i]);

    // Byte transfer 0xA5 at DIV=1, watched cycle by cycle via a held STATUS read
    tx_byte = 8'hA5;
    captured = 8'h00; edges = 0; busy_cycles = 0;
    clk_errs = 0; cmd_errs = 0; busy_errs = 0; prev_clk = 1'b0;
    bus_write(SD_ADDR_DATA, tx_byte);
    address = SD_ADDR_STAT; chipselect = 1'b1; read_n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      logic exp_clk, exp_cmd, exp_busy;
      #1;
      exp_busy = (i <= 32);
      exp_clk  = (i <= 32) && (((i - 1) % 4) >= 2);
      exp_cmd  = (i <= 32) ? tx_byte[7 - (i - 1) / 4] : 1'b1;
      if (sd_clk !== exp_clk) clk_errs++;
      if (sd_cmd_out !== exp_cmd) cmd_errs++;
      if (readdata[STAT_BUSY] !== exp_busy) busy_errs++;
      if (readdata[STAT_BUSY] === 1'b1) busy_cycles++;
      if (sd_clk && !prev_clk) begin
        edges++;
        captured = {captured[6:0], sd_cmd_out};
      end
      prev_clk = sd_clk;
      @(posedge clk);
    end
    #1 chipselect = 1'b0; read_n = 1'b1;
    checkOutput("byte sd_clk waveform errors", clk_errs, 0);
    checkOutput("byte cmd waveform errors", cmd_errs, 0);
    checkOutput("byte busy timing errors", busy_errs, 0);
    checkOutput("byte busy cycles", busy_cycles, 32);
    checkOutput("byte sd_clk rising edges", edges, 8);
    checkOutput("byte cmd bits at rising edges", captured, 8'hA5);
    bus_read(SD_ADDR_STAT, d);
    checkOutput("byte status done", d, 8'h02);
    bus_read(SD_ADDR_DATA, d);
    checkOutput("byte rxdata", d, 8'hA5);
    bus_read(SD_ADDR_STAT, d);
    checkOutput("done cleared by rxdata read", d, 8'h00);

    // 74 idle clocks at DIV=0
    bus_write(SD_ADDR_DIV, 8'h00);
    edges = 0; busy_cycles = 0; cmd_errs = 0; prev_clk = 1'b0; timed_out = 1'b1;
    bus_write(SD_ADDR_STAT, 8'd73);
    address = SD_ADDR_STAT; chipselect = 1'b1; read_n = 1'b0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (!readdata[STAT_BUSY]) begin
        timed_out = 1'b0;
        break;
      end
      busy_cycles++;
      if (sd_cmd_out !== 1'b1) cmd_errs++;
      if (sd_clk && !prev_clk) edges++;
      prev_clk = sd_clk;
      @(posedge clk);
    end
    chipselect = 1'b0; read_n = 1'b1;
    idle_cycles(1);
    checkOutput("idle transfer timeout", timed_out, 1'b0);
    checkOutput("idle sd_clk rising edges", edges, 74);
    checkOutput("idle busy cycles", busy_cycles, 148);
    checkOutput("idle cmd not high count", cmd_errs, 0);
    bus_read(SD_ADDR_STAT, d);
    checkOutput("idle status done", d, 8'h02);
    bus_read(SD_ADDR_DATA, d);
    checkOutput("idle rxdata unchanged", d, 8'hA5);

    // Start while busy: ignored, sticky ovr cleared by STATUS read
    bus_write(SD_ADDR_DIV, 8'h01);
    bus_write(SD_ADDR_DATA, 8'h3C);
    idle_cycles(3);
    bus_write(SD_ADDR_DATA, 8'h40);
    bus_read(SD_ADDR_STAT, d);
    checkOutput("overrun status", d, 8'h05);
    bus_read(SD_ADDR_STAT, d);
    checkOutput("ovr cleared by status read", d, 8'h01);
    wait_not_busy(100, ok);
    checkOutput("overrun transfer completes", ok, 1'b1);
    bus_read(SD_ADDR_DATA, d);
    checkOutput("overrun rxdata from first byte", d, 8'h3C);

    // Reset in the high half of bit 3
    bus_write(SD_ADDR_CTRL, 8'h01);
    checkOutput("cmd_oe follows ctrl", sd_cmd_oe, 1'b1);
    bus_write(SD_ADDR_DATA, 8'h00);
    idle_cycles(14);
    checkOutput("bit3 sd_clk high before reset", sd_clk, 1'b1);
    checkOutput("bit3 cmd low before reset", sd_cmd_out, 1'b0);
    reset = 1'b1;
    idle_cycles(1);
    checkOutput("reset mid sd_clk", sd_clk, 1'b0);
    checkOutput("reset mid sd_cmd_out", sd_cmd_out, 1'b1);
    checkOutput("reset mid sd_cmd_oe", sd_cmd_oe, 1'b0);
    address = SD_ADDR_STAT;
    #1 checkOutput("reset mid status", readdata, 8'h00);
    address = SD_ADDR_DIV;
    #1 checkOutput("reset mid div", readdata, 8'h3F);
    reset = 1'b0;
    idle_cycles(1);
    clk_errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (sd_clk !== 1'b0) clk_errs++;
      idle_cycles(1);
    end
    checkOutput("sd_clk stays low after reset", clk_errs, 0);

`ifdef SD_BUS_SEQ_IRQ_EN
    bus_write(SD_ADDR_DIV, 8'h01);
    bus_write(SD_ADDR_CTRL, 8'h03);
    bus_write(SD_ADDR_DATA, 8'h5A);
    checkOutput("irq low while busy", irq, 1'b0);
    wait_not_busy(100, ok);
    checkOutput("irq transfer completes", ok, 1'b1);
    checkOutput("irq set on done", irq, 1'b1);
    bus_read(SD_ADDR_DATA, d);
    checkOutput("irq rxdata", d, 8'h5A);
    checkOutput("irq cleared by rxdata read", irq, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
